divider_iterative: RTL and testbench
====================================

// Module: divider_iterative
// PURPOSE
// - Unsigned integer divider: the inverse operation of the pipelined array multiplier.
// - Computes one quotient bit per clock (restoring division) under a start/busy/done handshake.
// - Sits beside the multiplier in the datapath examples; y = a*b from the multiplier,
//   fed back as dividend with b as divisor, returns q = a, r = 0.
// PARAMETERS
// - width   4   operand width of divisor, quotient and remainder; dividend is 2*width bits.
// PORTS
// - clk          in   1          rising-edge clock
// - rst_n        in   1          asynchronous, active-low reset
// - start        in   1          request; sampled only in IDLE
// - a            in   2*width    dividend; sampled with start
// - b            in   width      divisor; sampled with start
// - q            out  2*width    quotient
// - r            out  width      remainder
// - busy         out  1          high in RUN and DONE
// - done         out  1          one-cycle pulse; q, r and dbz are valid while high
// - dbz          out  1          divide-by-zero flag for the last accepted operation
// BEHAVIOUR
// - Reset (rst_n=0, any time, asynchronous):
//   - state = IDLE; q, r, dbz, done, busy = 0; internal counter and registers cleared.
//   - An operation in flight is abandoned; no done is produced for it.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE: busy=0. On the edge E0 where start=1:
//     - capture a and b;
//     - b != 0: go to RUN, cnt = 0;
//     - b == 0: go to DONE directly, load q = all ones, r = 0, dbz = 1.
//   - RUN: busy=1. One iteration per edge for 2*width edges (E1 .. E(2*width)).
//     The final edge moves the state to DONE.
//   - DONE: busy=1, done=1 for exactly one cycle. Next edge goes to IDLE.
// - Iteration (restoring), over a partial remainder p of width+1 bits and a dividend shift register:
//   - shift {p, dividend} left by 1;
//   - if p >= b, then p = p - b and shift 1 into q; else shift 0 into q.
// - Final values: q = a / b, r = a % b, dbz = 0. For width=4, a=8'hFF, b=4'h1: q = 8'hFF, r = 0.
// - Latency:
//   - b != 0: done is high in the cycle after edge E(2*width), i.e. 2*width+1 edges after start
//     is sampled (9 edges for width=4);
//   - b == 0: done is high in the cycle after E0.
// - Throughput: the next start is accepted in IDLE, at earliest the edge after the done cycle.
// - start while busy=1 (RUN or DONE) is ignored; operands are not re-sampled.
// - q, r and dbz hold their values after done until the next accepted start.
//   They change only at DONE entry, never during RUN.
// - a and b may change freely after E0 without affecting the result.
// TESTING
// - width=4, a=8'd13, b=4'd3, start pulse -> done 9 edges later; q=8'd4, r=4'd1, dbz=0; busy high 9 cycles.
// - a=8'd7, b=4'd9 -> q=0, r=7. a=8'd225, b=4'd15 -> q=15, r=0. a=8'd255, b=4'd1 -> q=255, r=0.
// - a=8'd9, b=4'd0 -> done in the cycle after E0; q=8'hFF, r=0, dbz=1.
//   Then a=8'd10, b=4'd2 -> q=5, r=0, dbz=0.
// - start re-asserted every cycle of RUN with different a and b -> result still that of the first
//   operands; exactly one done pulse.
// - rst_n low at iteration 3 of a=8'd200, b=4'd7 -> q=r=busy=done=0 immediately, with no clock edge.
//   After release, a new start 200/7 -> q=28, r=4.
// - Random compare: 1000 random a and b (b != 0) against a/b and a%b from the model.
//   Check the done-to-start spacing is at least 1 idle cycle.

Source files
------------

// File: rtl/divider_iterative.sv
// Unsigned restoring divider: 2*width-bit dividend by width-bit divisor, one quotient bit per clock.
// Results are published only on entry to DONE and are held until the next accepted start.
//
// state  | meaning
// IDLE   | waiting for start; operands sampled on the start edge
// RUN    | one restoring iteration per edge, 2*width edges in total
// DONE   | one-cycle done pulse; q, r, dbz valid
module divider_iterative #(
  parameter int width = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*width-1:0]   a,
  input  logic [width-1:0]     b,
  output logic [2*width-1:0]   q,
  output logic [width-1:0]     r,
  output logic                 busy,
  output logic                 done,
  output logic                 dbz
);

  localparam int n  = 2 * width;
  localparam int cw = (n > 2) ? $clog2(n) : 1;
  localparam logic [cw-1:0] cnt_last = cw'(n - 1);

  localparam logic [1:0] s_idle = 2'd0;
  localparam logic [1:0] s_run  = 2'd1;
  localparam logic [1:0] s_done = 2'd2;

  logic [1:0]       state;
  logic [cw-1:0]    cnt;
  logic [width:0]   p;
  logic [n-1:0]     dvd;
  logic [n-1:0]     quo;
  logic [width-1:0] dsr;

  logic [width:0]   p_sh;
  logic [width:0]   p_nxt;
  logic             bit_q;

  // p stays below the divisor between iterations, so the shifted value fits in width+1 bits
  always_comb begin
    p_sh  = {p[width-1:0], dvd[n-1]};
    bit_q = (p_sh >= {1'b0, dsr});
    p_nxt = bit_q ? (p_sh - {1'b0, dsr}) : p_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= s_idle;
      cnt   <= '0;
      p     <= '0;
      dvd   <= '0;
      quo   <= '0;
      dsr   <= '0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        s_idle: begin
          if (start) begin
            dvd <= a;
            dsr <= b;
            p   <= '0;
            quo <= '0;
            cnt <= '0;
            if (b == '0) begin
              q     <= '1;
              r     <= '0;
              dbz   <= 1'b1;
              state <= s_done;
            end else begin
              state <= s_run;
            end
          end
        end
        s_run: begin
          p   <= p_nxt;
          dvd <= {dvd[n-2:0], 1'b0};
          quo <= {quo[n-2:0], bit_q};
          cnt <= cnt + cw'(1);
          if (cnt == cnt_last) begin
            q     <= {quo[n-2:0], bit_q};
            r     <= p_nxt[width-1:0];
            dbz   <= 1'b0;
            state <= s_done;
          end
        end
        s_done:  state <= s_idle;
        default: state <= s_idle;
      endcase
    end
  end

  assign busy = (state != s_idle);
  assign done = (state == s_done);

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative (width=4): vector table, corner sequences, random ops.
// Expected results go into a scoreboard queue at start and are compared when done rises.
module tb_divider_iterative;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [3:0] b;
  logic [7:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       dbz;

  int n_vec = 0;
  int n_err = 0;
  vec_t sb[$];

  divider_iterative #(.width(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one start and follows the op until done plus one idle cycle.
  task automatic run_op(input vec_t v, input bit spam);
    int lat, busy_cnt, done_cnt, extra;
    bit held;
    logic [7:0] q_hold;
    logic [3:0] r_hold;
    vec_t e;
    q_hold = q; r_hold = r; held = 1'b1;
    sb.push_back(v);
    a = v.a; b = v.b; start = 1'b1;
    lat = 0; busy_cnt = 0; done_cnt = 0;
    while (done_cnt == 0 && lat < 30) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (spam) begin
        start = 1'b1; a = 8'($urandom); b = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) done_cnt++;
      else if (q !== q_hold || r !== r_hold) held = 1'b0;
    end
    e = sb.pop_front();
    if (done_cnt == 0) begin
      chk("done_timeout", 32'(done_cnt), 32'd1);
    end else begin
      chk("q", 32'(q), 32'(e.q));
      chk("r", 32'(r), 32'(e.r));
      chk("dbz", 32'(dbz), 32'(e.dbz));
      chk("latency", 32'(lat), e.dbz ? 32'd1 : 32'd9);
      chk("busy_cycles", 32'(busy_cnt), e.dbz ? 32'd1 : 32'd9);
      chk("outputs_held_in_run", 32'(held), 32'd1);
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("result_held_q", 32'(q), 32'(e.q));
    if (spam) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk("single_done_pulse", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    vec_t tbl[11];
    vec_t v;
    int extra;
    tbl[0]  = '{a: 8'd13,  b: 4'd3,  q: 8'd4,   r: 4'd1, dbz: 1'b0};
    tbl[1]  = '{a: 8'd7,   b: 4'd9,  q: 8'd0,   r: 4'd7, dbz: 1'b0};
    tbl[2]  = '{a: 8'd225, b: 4'd15, q: 8'd15,  r: 4'd0, dbz: 1'b0};
    tbl[3]  = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, dbz: 1'b0};
    tbl[4]  = '{a: 8'd9,   b: 4'd0,  q: 8'd255, r: 4'd0, dbz: 1'b1};
    tbl[5]  = '{a: 8'd10,  b: 4'd2,  q: 8'd5,   r: 4'd0, dbz: 1'b0};
    tbl[6]  = '{a: 8'd0,   b: 4'd5,  q: 8'd0,   r: 4'd0, dbz: 1'b0};
    tbl[7]  = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0, dbz: 1'b0};
    tbl[8]  = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4, dbz: 1'b0};
    tbl[9]  = '{a: 8'd128, b: 4'd3,  q: 8'd42,  r: 4'd2, dbz: 1'b0};
    tbl[10] = '{a: 8'd255, b: 4'd2,  q: 8'd127, r: 4'd1, dbz: 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_r", 32'(r), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dbz", 32'(dbz), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) run_op(tbl[i], 1'b0);

    // start held high through RUN and DONE with changing operands
    v = '{a: 8'd100, b: 4'd9, q: 8'd11, r: 4'd1, dbz: 1'b0};
    run_op(v, 1'b1);

    // asynchronous abort mid-operation
    a = 8'd200; b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("no_done_after_abort", 32'(extra), 32'd0);
    v = '{a: 8'd200, b: 4'd7, q: 8'd28, r: 4'd4, dbz: 1'b0};
    run_op(v, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      v.a = 8'($urandom);
      v.b = 4'($urandom_range(1, 15));
      v.q = v.a / 8'(v.b);
      v.r = 4'(v.a % 8'(v.b));
      v.dbz = 1'b0;
      run_op(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
